// File: rtl/grn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grn_pkg
// Description : Shared types and constants for the GRN attractor search engine.
// Revision    : 1.0 - initial release
// ============================================================================
package grn_pkg;

    localparam logic [1:0] c_STATUS_NONE    = 2'd0;
    localparam logic [1:0] c_STATUS_FIXED   = 2'd1;
    localparam logic [1:0] c_STATUS_CYCLE   = 2'd2;
    localparam logic [1:0] c_STATUS_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        ST_NONE    = c_STATUS_NONE,
        ST_FIXED   = c_STATUS_FIXED,
        ST_CYCLE   = c_STATUS_CYCLE,
        ST_TIMEOUT = c_STATUS_TIMEOUT
    } status_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    // Index width of the history CAM; a single-entry history still needs one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/grn_history_cam.sv
`default_nettype none
// ============================================================================
// Module      : grn_history_cam
// Description : Shift-register history of past states with parallel compare
//               and lowest-index priority encoding of the match.
// Revision    : 1.0 - initial release
// ============================================================================
module grn_history_cam
    import grn_pkg::*;
#(
    parameter int N_NODES    = 20,
    parameter int HIST_DEPTH = 8,
    localparam int IDX_W     = idx_width(HIST_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               push,
    input  logic [N_NODES-1:0] push_data,
    input  logic [N_NODES-1:0] cmp_data,
    output logic               hit,
    output logic [IDX_W-1:0]   hit_idx
);

    logic [N_NODES-1:0]    r_hist [HIST_DEPTH];
    logic [HIST_DEPTH-1:0] r_valid;
    logic [HIST_DEPTH-1:0] w_match;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                r_hist[i] <= '0;
            end
        end else if (clear) begin
            r_valid <= '0;
        end else if (push) begin
            for (int i = HIST_DEPTH - 1; i > 0; i--) begin
                r_hist[i]  <= r_hist[i-1];
                r_valid[i] <= r_valid[i-1];
            end
            r_hist[0]  <= push_data;
            r_valid[0] <= 1'b1;
        end
    end

    for (genvar g = 0; g < HIST_DEPTH; g++) begin : g_cmp
        assign w_match[g] = r_valid[g] && (r_hist[g] == cmp_data);
    end

    // Scan downwards so the lowest matching index (shortest period) wins.
    always_comb begin
        hit_idx = '0;
        for (int j = HIST_DEPTH - 1; j >= 0; j--) begin
            if (w_match[j]) begin
                hit_idx = IDX_W'(j);
            end
        end
    end

    assign hit = |w_match;

endmodule
`default_nettype wire

// File: rtl/grn_attractor_engine.sv
`default_nettype none
// ============================================================================
// Module      : grn_attractor_engine
// Description : Iterates an external Boolean next-state function one step per
//               clock and reports fixed point, limit cycle or timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module grn_attractor_engine
    import grn_pkg::*;
#(
    parameter int N_NODES    = 20,
    parameter int HIST_DEPTH = 8,
    parameter int MAX_STEPS  = 1024,
    localparam int PERIOD_W  = $clog2(HIST_DEPTH + 2),
    localparam int STEPS_W   = $clog2(MAX_STEPS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [N_NODES-1:0]  init_state,
    output logic [N_NODES-1:0]  cur_state,
    input  logic [N_NODES-1:0]  next_state,
    output logic                busy,
    output logic                done,
    output logic [1:0]          status,
    output logic [PERIOD_W-1:0] period,
    output logic [STEPS_W-1:0]  steps,
    output logic [N_NODES-1:0]  attractor_state
);

    localparam int IDX_W = idx_width(HIST_DEPTH);

    fsm_t                r_state, w_state_nxt;
    logic [N_NODES-1:0]  r_cur, r_attr;
    logic [STEPS_W-1:0]  r_step_cnt, r_steps, w_cnt_inc;
    logic [PERIOD_W-1:0] r_period, w_period;
    status_t             r_status, w_status;
    logic                r_done;
    logic                w_hit;
    logic [IDX_W-1:0]    w_hit_idx;
    logic                w_fixed, w_match, w_timeout;
    logic                w_accept, w_finish, w_push;

    grn_history_cam #(
        .N_NODES    (N_NODES),
        .HIST_DEPTH (HIST_DEPTH)
    ) u_cam (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_accept),
        .push      (w_push),
        .push_data (r_cur),
        .cmp_data  (next_state),
        .hit       (w_hit),
        .hit_idx   (w_hit_idx)
    );

    always_comb begin
        w_fixed     = (next_state == r_cur);
        w_match     = w_fixed | w_hit;
        w_cnt_inc   = r_step_cnt + 1'b1;
        w_timeout   = (w_cnt_inc == STEPS_W'(MAX_STEPS));
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        w_push      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!abort && start) begin
                    w_state_nxt = S_RUN;
                    w_accept    = 1'b1;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_push = !w_match;
                    if (w_match || w_timeout) begin
                        w_state_nxt = S_DONE;
                        w_finish    = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (start) begin
                    w_state_nxt = S_RUN;
                    w_accept    = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Result encoding; a match outranks a timeout in the same cycle.
        if (w_fixed) begin
            w_status = ST_FIXED;
            w_period = PERIOD_W'(1);
        end else if (w_hit) begin
            w_status = ST_CYCLE;
            w_period = PERIOD_W'(w_hit_idx) + PERIOD_W'(2);
        end else begin
            w_status = ST_TIMEOUT;
            w_period = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cur      <= '0;
            r_step_cnt <= '0;
            r_done     <= 1'b0;
            r_status   <= ST_NONE;
            r_period   <= '0;
            r_steps    <= '0;
            r_attr     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_finish;
            if (w_accept) begin
                r_cur      <= init_state;
                r_step_cnt <= '0;
                r_status   <= ST_NONE;
                r_period   <= '0;
                r_steps    <= '0;
                r_attr     <= '0;
            end
            if (w_push) begin
                r_cur      <= next_state;
                r_step_cnt <= w_cnt_inc;
            end
            if (w_finish) begin
                r_status <= w_status;
                r_period <= w_period;
                r_steps  <= w_match ? r_step_cnt : w_cnt_inc;
                r_attr   <= next_state;
            end
        end
    end

    assign cur_state       = r_cur;
    assign busy            = (r_state == S_RUN);
    assign done            = r_done;
    assign status          = r_status;
    assign period          = r_period;
    assign steps           = r_steps;
    assign attractor_state = r_attr;

endmodule
`default_nettype wire

// File: tb/tb_grn_attractor_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_grn_attractor_engine
// Description : Directed self-checking bench for grn_attractor_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grn_attractor_engine;

    localparam int c_N = 20;

    logic           clk;
    logic           rst;
    logic           start;
    logic           abort;
    logic [c_N-1:0] init_state;
    logic [c_N-1:0] cur_state;
    logic [c_N-1:0] next_state;
    logic           busy;
    logic           done;
    logic [1:0]     status;
    logic [3:0]     period;
    logic [10:0]    steps;
    logic [c_N-1:0] attractor_state;
    logic [1:0]     mode;

    int n_checks = 0;
    int n_pass   = 0;

    grn_attractor_engine #(
        .N_NODES    (20),
        .HIST_DEPTH (8),
        .MAX_STEPS  (1024)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .init_state      (init_state),
        .cur_state       (cur_state),
        .next_state      (next_state),
        .busy            (busy),
        .done            (done),
        .status          (status),
        .period          (period),
        .steps           (steps),
        .attractor_state (attractor_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External update function: 0 identity, 1 rotate-left, 2 increment.
    always_comb begin
        next_state = cur_state;
        case (mode)
            2'd1:    next_state = {cur_state[c_N-2:0], cur_state[c_N-1]};
            2'd2:    next_state = cur_state + 20'd1;
            default: next_state = cur_state;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic launch(input logic [1:0] m, input logic [c_N-1:0] init);
        mode       = m;
        init_state = init;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int k);
        k = 0;
        do begin
            tick();
            k++;
        end while (!done && k < budget);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   32'(busy),            32'd0);
        check({tag, "_done"},   32'(done),            32'd0);
        check({tag, "_status"}, 32'(status),          32'd0);
        check({tag, "_period"}, 32'(period),          32'd0);
        check({tag, "_steps"},  32'(steps),           32'd0);
        check({tag, "_attr"},   32'(attractor_state), 32'd0);
        check({tag, "_cur"},    32'(cur_state),       32'd0);
    endtask

    initial begin
        int   lat;
        logic seen;

        rst = 1'b1; start = 1'b0; abort = 1'b0; init_state = '0; mode = 2'd0;
        tick(); tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Identity: immediate fixed point
        launch(2'd0, 20'h12345);
        check("id_busy", 32'(busy), 32'd1);
        check("id_cur",  32'(cur_state), 32'h12345);
        wait_done(1100, lat);
        check("id_lat",    32'(lat), 32'd1);
        check("id_status", 32'(status), 32'd1);
        check("id_period", 32'(period), 32'd1);
        check("id_steps",  32'(steps), 32'd0);
        check("id_attr",   32'(attractor_state), 32'h12345);
        check("id_busy_done", 32'(busy), 32'd0);
        tick();
        check("id_done_pulse", 32'(done), 32'd0);
        check("id_status_hold", 32'(status), 32'd1);

        // Rotate, period 4
        launch(2'd1, 20'h11111);
        wait_done(1100, lat);
        check("rot4_lat",    32'(lat), 32'd4);
        check("rot4_status", 32'(status), 32'd2);
        check("rot4_period", 32'(period), 32'd4);
        check("rot4_steps",  32'(steps), 32'd3);
        check("rot4_attr",   32'(attractor_state), 32'h11111);

        // Rotate, period 20 exceeds history: timeout
        launch(2'd1, 20'h00001);
        wait_done(1100, lat);
        check("rot20_lat",    32'(lat), 32'd1024);
        check("rot20_status", 32'(status), 32'd3);
        check("rot20_period", 32'(period), 32'd0);
        check("rot20_steps",  32'(steps), 32'd1024);
        check("rot20_attr",   32'(attractor_state), 32'h00010);

        // Increment across the 20-bit wrap
        launch(2'd2, 20'hFFFF0);
        wait_done(1100, lat);
        check("inc_lat",    32'(lat), 32'd1024);
        check("inc_status", 32'(status), 32'd3);
        check("inc_period", 32'(period), 32'd0);
        check("inc_steps",  32'(steps), 32'd1024);
        check("inc_attr",   32'(attractor_state), 32'h003F0);

        // Abort at step 10
        launch(2'd1, 20'h00001);
        repeat (10) tick();
        check("ab_busy_run", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy",   32'(busy), 32'd0);
        check("ab_done",   32'(done), 32'd0);
        check("ab_status", 32'(status), 32'd0);
        check("ab_steps",  32'(steps), 32'd0);
        seen = 1'b0;
        repeat (5) begin
            tick();
            seen = seen | done;
        end
        check("ab_no_done", 32'(seen), 32'd0);
        launch(2'd1, 20'h11111);
        wait_done(1100, lat);
        check("ab_next_lat",    32'(lat), 32'd4);
        check("ab_next_status", 32'(status), 32'd2);

        // Reset at step 10
        launch(2'd1, 20'h00001);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("rst_mid");
        launch(2'd0, 20'h12345);
        wait_done(1100, lat);
        check("rst_next_lat",    32'(lat), 32'd1);
        check("rst_next_status", 32'(status), 32'd1);
        check("rst_next_attr",   32'(attractor_state), 32'h12345);

        // Start held during RUN is ignored
        launch(2'd1, 20'h11111);
        start = 1'b1;
        init_state = 20'h00001;
        tick(); tick();
        start = 1'b0;
        wait_done(1100, lat);
        check("b2b_lat",    32'(lat + 2), 32'd4);
        check("b2b_status", 32'(status), 32'd2);
        check("b2b_attr",   32'(attractor_state), 32'h11111);
        check("b2b_period", 32'(period), 32'd4);

        // Start coinciding with the done cycle
        check("b2b_done_now", 32'(done), 32'd1);
        launch(2'd0, 20'h54321);
        check("b2b_restart_busy",   32'(busy), 32'd1);
        check("b2b_restart_cur",    32'(cur_state), 32'h54321);
        check("b2b_restart_status", 32'(status), 32'd0);
        wait_done(1100, lat);
        check("b2b_restart_lat",  32'(lat), 32'd1);
        check("b2b_restart_attr", 32'(attractor_state), 32'h54321);

        // Start together with abort from DONE
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("sa_busy",   32'(busy), 32'd0);
        check("sa_status", 32'(status), 32'd1);
        tick();
        check("sa_busy2", 32'(busy), 32'd0);
        check("sa_done",  32'(done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
